i2c_op_scheduler: RTL
=====================

Name: i2c_op_scheduler

Overview:
- Sits between the UART-to-I2C instruction path and the I2C master (i2cmaster), and decides which operation the I2C master runs next.
- Buffers PC-issued instructions in a small FIFO and generates periodic default 2-byte temperature reads.
- Arbitrates PC instructions against default reads (PC wins), honours result-buffer backpressure, and supervises each transaction with a completion watchdog.

Parameters:
- SYS_FREQ, 100000000: system clock frequency in Hz.
- POLL_CYCLES, 25000000: clock cycles between default temperature reads (250 ms at 100 MHz). Must be at least 2.
- DEPTH, 4: PC instruction FIFO depth. Must be a power of two, at least 2.
- WDT_CYCLES, 2000000: maximum cycles allowed between i2c_start and i2c_done.
- DEF_MODE, 8'h02: mode byte for a default read (read 2 bytes).
- DEF_ADDR, 8'h00: register address for a default read (ADT7420 temperature MSB).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: PC instruction present on cmd_mode/cmd_addr/cmd_data.
- cmd_ready, out, 1: FIFO can accept an instruction.
- cmd_mode, in, 8: operation byte of the PC instruction.
- cmd_addr, in, 8: target register address.
- cmd_data, in, 16: write data; byte 1 in [7:0], byte 2 in [15:8].
- i2c_ready, in, 1: I2C master idle (master_free).
- result_full, in, 1: downstream I2C-to-UART result buffer is full.
- i2c_done, in, 1: single-cycle completion pulse from the I2C master.
- i2c_start, out, 1: single-cycle issue pulse.
- i2c_mode, out, 8: mode of the issued operation.
- i2c_address, out, 8: register address of the issued operation.
- i2c_data, out, 16: write data of the issued operation.
- i2c_source, out, 1: 1 = PC instruction, 0 = default read.
- queue_count, out, $clog2(DEPTH)+1: number of FIFO entries.
- busy, out, 1: high in ISSUE and WAIT_DONE.
- watchdog_err, out, 1: single-cycle pulse on transaction timeout.

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high.
- Reset values:
  - All outputs 0, except cmd_ready = 1.
  - FIFO empty, pointers 0.
  - Poll counter 0; default_pending = 0.
  - Watchdog counter 0; FSM in IDLE.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = (queue_count < DEPTH). Registered count; no push-through-when-full, even on a same-cycle pop.
  - Simultaneous push and pop (not full): count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - cmd_valid while full: the instruction is ignored, not stored.
- Poll timer:
  - Free-running, counts 0 .. POLL_CYCLES-1 and wraps.
  - At POLL_CYCLES-1, sets default_pending.
  - Repeated ticks while pending coalesce into one request.
  - default_pending clears on the cycle a default read is issued. If a tick lands on that same cycle, the set wins.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE, when i2c_ready = 1:
  - If FIFO is non-empty and result_full = 0: pop the head, latch its fields onto the i2c_* outputs, set i2c_source = 1, go to ISSUE.
  - Else if default_pending: latch DEF_MODE/DEF_ADDR/16'h0000, set i2c_source = 0, go to ISSUE. Default reads ignore result_full because they are not buffered downstream.
  - Otherwise stay in IDLE.
- ISSUE: i2c_start = 1 for exactly this cycle; clear the watchdog counter; go to WAIT_DONE.
- WAIT_DONE:
  - On i2c_done, go to IDLE.
  - Otherwise increment the watchdog counter. When it reaches WDT_CYCLES-1, pulse watchdog_err and go to IDLE.
  - A timed-out PC instruction is dropped, not retried.
- Payload: i2c_mode, i2c_address, i2c_data and i2c_source hold stable from ISSUE until the next issue.
- i2c_done outside WAIT_DONE (including in ISSUE) is ignored.
- Latency:
  - Instruction pushed at cycle N, with FSM in IDLE and i2c_ready high: i2c_start is high at cycle N+2.
  - After i2c_done at cycle M, the next issue's i2c_start is at M+2 at the earliest.
- Reset mid-transaction: return to IDLE immediately and discard FIFO contents. The I2C master is reset by the same signal.

Test Plan:
- Reset, then idle for POLL_CYCLES = 10 with i2c_ready = 1: i2c_start at cycle 11 with i2c_mode = 8'h02, i2c_address = 8'h00, i2c_source = 0; i2c_done 5 cycles later returns the FSM to IDLE.
- Push {mode 8'h04, addr 8'h03, data 16'h00A5} while a default read is pending: the PC instruction issues first with i2c_source = 1 and i2c_data = 16'h00A5; the default read issues after its i2c_done.
- Push 5 instructions back-to-back into DEPTH = 4 with i2c_ready = 0: cmd_ready drops after the 4th, the 5th is dropped, queue_count = 4; raise i2c_ready and the four issue in push order.
- result_full = 1 with 2 instructions queued and a default read pending: only the default read issues and queue_count stays 2; deassert result_full and both PC instructions issue.
- WDT_CYCLES = 20 with no i2c_done after issue: watchdog_err pulses exactly once, about 20 cycles after i2c_start; FSM returns to IDLE and the next queued instruction issues.
- Assert reset in WAIT_DONE with 3 queued instructions: next cycle all outputs are 0, queue_count = 0, cmd_ready = 1, and no issue occurs before a new push or poll tick.

Source files
------------

// File: rtl/i2c_op_scheduler_if.sv
// Command, issue and status signals between i2c_op_scheduler and its environment.
// master: the scheduler (takes PC instructions, drives the I2C master's operation fields).
// slave: the environment (UART instruction path, I2C master, result buffer).
interface i2c_op_scheduler_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_mode;
  logic [7:0]    cmd_addr;
  logic [15:0]   cmd_data;
  logic          i2c_ready;
  logic          result_full;
  logic          i2c_done;
  logic          i2c_start;
  logic [7:0]    i2c_mode;
  logic [7:0]    i2c_address;
  logic [15:0]   i2c_data;
  logic          i2c_source;
  logic [CW-1:0] queue_count;
  logic          busy;
  logic          watchdog_err;

  modport master (
    input  cmd_valid, cmd_mode, cmd_addr, cmd_data, i2c_ready, result_full, i2c_done,
    output cmd_ready, i2c_start, i2c_mode, i2c_address, i2c_data, i2c_source,
           queue_count, busy, watchdog_err
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_addr, cmd_data, i2c_ready, result_full, i2c_done,
    input  cmd_ready, i2c_start, i2c_mode, i2c_address, i2c_data, i2c_source,
           queue_count, busy, watchdog_err
  );
endinterface

// File: rtl/i2c_op_scheduler.sv
// Purpose: picks the next I2C operation: queued PC instructions first, else a periodic default read.
// Latency: push at cycle N -> i2c_start at N+2 (idle, i2c_ready high); i2c_done at M -> next start >= M+2.
// Backpressure: cmd_ready low while the FIFO is full; PC issues held while result_full; watchdog aborts hangs.
// Ports: clk/reset (sync, active-high); bus.master carries the cmd_* instruction handshake,
// i2c_ready/result_full/i2c_done from downstream, the registered i2c_* issue fields, and
// queue_count/busy/watchdog_err status.
module i2c_op_scheduler #(
  parameter int unsigned SYS_FREQ    = 100000000,
  parameter int unsigned POLL_CYCLES = 25000000,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WDT_CYCLES  = 2000000,
  parameter logic [7:0]  DEF_MODE    = 8'h02,
  parameter logic [7:0]  DEF_ADDR    = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  i2c_op_scheduler_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(POLL_CYCLES);
  localparam int unsigned WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_CYCLES - 1);
  localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_CYCLES - 1);

  if (SYS_FREQ == 0 || POLL_CYCLES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("i2c_op_scheduler: invalid SYS_FREQ/POLL_CYCLES/DEPTH");
  end

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  addr;
    logic [7:0]  mode;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [WW-1:0] wdt_q, wdt_d;
  logic          pend_q, pend_d;
  logic          start_q, start_d;
  logic          src_q, src_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [7:0]    mode_q, mode_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          cmd_ready, push, pop, tick, issue_def;

  // Ready comes from the registered count only, so a full FIFO refuses
  // a push even when the head is being popped in the same cycle.
  assign cmd_ready = (count_q < CW'(DEPTH));
  assign push      = bus.cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wdt_d     = wdt_q;
    start_d   = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    src_d     = src_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    data_d    = data_q;
    pop       = 1'b0;
    issue_def = 1'b0;
    tick      = (poll_q == POLL_MAX);
    poll_d    = tick ? '0 : poll_q + PW'(1);

    case (state_q)
      IDLE: begin
        if (bus.i2c_ready) begin
          if (count_q != '0 && !bus.result_full) begin
            pop     = 1'b1;
            mode_d  = head.mode;
            addr_d  = head.addr;
            data_d  = head.data;
            src_d   = 1'b1;
            start_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ISSUE;
          end else if (pend_q) begin
            // Default reads bypass result_full: their data is not buffered downstream.
            issue_def = 1'b1;
            mode_d    = DEF_MODE;
            addr_d    = DEF_ADDR;
            data_d    = 16'h0000;
            src_d     = 1'b0;
            start_d   = 1'b1;
            busy_d    = 1'b1;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        wdt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i2c_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wdt_q == WDT_MAX) begin
          // The timed-out operation is abandoned, not retried.
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wdt_d = wdt_q + WW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // A tick on the issue cycle re-arms the request (set wins over clear).
    pend_d = tick | (pend_q & ~issue_def);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      poll_q   <= '0;
      pend_q   <= 1'b0;
      wdt_q    <= '0;
      start_q  <= 1'b0;
      src_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      mode_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      poll_q   <= poll_d;
      pend_q   <= pend_d;
      wdt_q    <= wdt_d;
      start_q  <= start_d;
      src_q    <= src_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{data: bus.cmd_data, addr: bus.cmd_addr, mode: bus.cmd_mode};
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.i2c_start    = start_q;
  assign bus.i2c_mode     = mode_q;
  assign bus.i2c_address  = addr_q;
  assign bus.i2c_data     = data_q;
  assign bus.i2c_source   = src_q;
  assign bus.queue_count  = count_q;
  assign bus.busy         = busy_q;
  assign bus.watchdog_err = err_q;
endmodule
